fetch_controller: RTL and testbench

Instruction-fetch sequencer for the program code memory (9-bit word address, 16-bit instruction, one-cycle synchronous read). Holds the program counter and drives the code memory address. Captures each returned word and hands it to the decoder over a valid/ready handshake. Handles jumps, halt and PC wrap-around.

---
 rtl/fetch_controller.sv | 88 ++++++++
 tb/tb_fetch_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for a one-cycle synchronous code memory,
// with valid/ready hand-off to the decoder, jump flush, halt and sticky PC wrap flag.
module fetch_controller #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_enable,
  input  logic                  in_jump_valid,
  input  logic [ADDR_WIDTH-1:0] in_jump_addr,
  input  logic                  in_halt,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_instr_pc,
  output logic                  out_instr_valid,
  input  logic                  in_instr_ready,
  output logic                  out_halted,
  output logic                  out_wrapped
);
  typedef enum logic [2:0] {IDLE, FETCH, DATA, HOLD, HALTED} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d, wrapped_q, wrapped_d;
  logic [ADDR_WIDTH:0] pc_inc;
  assign pc_inc = {1'b0, pc_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      wrapped_q  <= wrapped_d;
    end
  end
  // Halt beats jump beats sequencing; HALTED is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q != HALTED) begin
      if (in_halt) state_d = HALTED;
      else if (in_jump_valid) state_d = FETCH;
      else case (state_q)
        IDLE:    state_d = in_enable ? FETCH : IDLE;
        FETCH:   state_d = DATA;
        DATA:    state_d = HOLD;
        HOLD:    state_d = in_instr_ready ? (in_enable ? FETCH : IDLE) : HOLD;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    wrapped_d  = wrapped_q;
    if (state_q != HALTED) begin
      if (in_halt) valid_d = 1'b0;
      else if (in_jump_valid) begin
        pc_d    = in_jump_addr;
        valid_d = 1'b0;
      end else if (state_q == DATA) begin
        instr_d    = in_mem_data;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_inc[ADDR_WIDTH-1:0];
        wrapped_d  = wrapped_q | pc_inc[ADDR_WIDTH];
      end else if (state_q == HOLD && in_instr_ready) valid_d = 1'b0;
    end
  end
  assign out_mem_addr    = pc_q;
  assign out_instr       = instr_q;
  assign out_instr_pc    = instr_pc_q;
  assign out_instr_valid = valid_q;
  assign out_halted      = state_q == HALTED;
  assign out_wrapped     = wrapped_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed stimulus with a scoreboard queue of expected
// instructions, drained by a monitor on every handshake transfer.
module tb_fetch_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_enable = 1'b0;
  logic in_jump_valid = 1'b0;
  logic [8:0] in_jump_addr = '0;
  logic in_halt = 1'b0;
  logic [8:0] out_mem_addr;
  logic [15:0] in_mem_data = '0;
  logic [15:0] out_instr;
  logic [8:0] out_instr_pc;
  logic out_instr_valid;
  logic in_instr_ready = 1'b0;
  logic out_halted;
  logic out_wrapped;
  logic [15:0] mem [512];
  logic [24:0] sb [$];
  logic [24:0] e;
  int checks = 0;
  int errors = 0;

  fetch_controller dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_jump_valid(in_jump_valid),
    .in_jump_addr(in_jump_addr), .in_halt(in_halt), .out_mem_addr(out_mem_addr),
    .in_mem_data(in_mem_data), .out_instr(out_instr), .out_instr_pc(out_instr_pc),
    .out_instr_valid(out_instr_valid), .in_instr_ready(in_instr_ready),
    .out_halted(out_halted), .out_wrapped(out_wrapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) in_mem_data <= mem[out_mem_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_valid", 32'(out_instr_valid), 0);
    chk("rst_instr", 32'(out_instr), 0);
    chk("rst_instr_pc", 32'(out_instr_pc), 0);
    chk("rst_halted", 32'(out_halted), 0);
    chk("rst_wrapped", 32'(out_wrapped), 0);
    chk("rst_addr", 32'(out_mem_addr), 0);
  endtask

  always @(negedge clk)
    if (!reset && out_instr_valid && in_instr_ready && !in_halt && !in_jump_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer got %h@%h expected none", out_instr, out_instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", 32'(out_instr), 32'(e[15:0]));
        chk("sb_instr_pc", 32'(out_instr_pc), 32'(e[24:16]));
      end
    end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 ^ 16'(i);
    mem[0] = 16'hF0F0;
    mem[1] = 16'h0F0F;
    // 1: latency and back-to-back delivery
    tick;
    reset = 1'b0;
    chk_reset_vals();
    in_enable = 1'b1;
    in_instr_ready = 1'b1;
    sb.push_back({9'd0, 16'hF0F0});
    sb.push_back({9'd1, 16'h0F0F});
    tick;
    chk("t1_valid_e", 32'(out_instr_valid), 0);
    tick;
    chk("t1_valid_e1", 32'(out_instr_valid), 0);
    tick;
    chk("t1_valid_e2", 32'(out_instr_valid), 1);
    repeat (3) tick;
    chk("t1_valid_e5", 32'(out_instr_valid), 1);
    chk("t1_instr_e5", 32'(out_instr), 32'h0F0F);
    in_enable = 1'b0;
    tick;
    chk("t1_idle_valid", 32'(out_instr_valid), 0);
    chk("t1_idle_addr", 32'(out_mem_addr), 2);
    // 2: decoder stall holds everything stable
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_reset_vals();
    in_enable = 1'b1;
    in_instr_ready = 1'b0;
    sb.push_back({9'd0, 16'hF0F0});
    repeat (3) tick;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(out_instr_valid), 1);
      chk("t2_hold_instr", 32'(out_instr), 32'hF0F0);
      chk("t2_hold_addr", 32'(out_mem_addr), 1);
      tick;
    end
    in_instr_ready = 1'b1;
    tick;
    chk("t2_xfer_valid", 32'(out_instr_valid), 0);
    in_instr_ready = 1'b0;
    tick;
    tick;
    chk("t2_hold2_valid", 32'(out_instr_valid), 1);
    chk("t2_hold2_pc", 32'(out_instr_pc), 1);
    // 3: jump in HOLD with ready wins over transfer, then wrap
    in_jump_valid = 1'b1;
    in_jump_addr = 9'h1FF;
    in_instr_ready = 1'b1;
    tick;
    in_jump_valid = 1'b0;
    chk("t3_flush_valid", 32'(out_instr_valid), 0);
    chk("t3_jump_addr", 32'(out_mem_addr), 32'h1FF);
    chk("t3_no_wrap_on_jump", 32'(out_wrapped), 0);
    sb.push_back({9'h1FF, 16'hA1FF});
    tick;
    tick;
    chk("t3_1ff_valid", 32'(out_instr_valid), 1);
    chk("t3_wrapped", 32'(out_wrapped), 1);
    chk("t3_addr_wrap", 32'(out_mem_addr), 0);
    repeat (3) tick;
    chk("t3_next_valid", 32'(out_instr_valid), 1);
    chk("t3_next_pc", 32'(out_instr_pc), 0);
    chk("t3_next_instr", 32'(out_instr), 32'hF0F0);
    // 4: halt beats jump and transfer; HALTED ignores everything
    in_halt = 1'b1;
    in_jump_valid = 1'b1;
    in_jump_addr = 9'h055;
    tick;
    in_halt = 1'b0;
    in_jump_valid = 1'b0;
    chk("t4_halted", 32'(out_halted), 1);
    chk("t4_valid", 32'(out_instr_valid), 0);
    chk("t4_pc", 32'(out_mem_addr), 1);
    chk("t4_instr_pc", 32'(out_instr_pc), 0);
    for (int i = 0; i < 4; i++) begin
      in_enable = 1'(i & 1);
      in_jump_valid = ~in_enable;
      tick;
      chk("t4_stay_halted", 32'(out_halted), 1);
      chk("t4_stay_pc", 32'(out_mem_addr), 1);
      chk("t4_stay_valid", 32'(out_instr_valid), 0);
    end
    in_jump_valid = 1'b0;
    // 5: reset during DATA discards the in-flight word
    reset = 1'b1;
    tick;
    reset = 1'b0;
    in_enable = 1'b1;
    in_instr_ready = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    in_enable = 1'b0;
    chk_reset_vals();
    repeat (4) tick;
    chk("t5_idle_valid", 32'(out_instr_valid), 0);
    // 6: enable dropped in FETCH still completes, then IDLE
    in_enable = 1'b1;
    in_instr_ready = 1'b0;
    sb.push_back({9'd0, 16'hF0F0});
    tick;
    in_enable = 1'b0;
    tick;
    tick;
    chk("t6_valid", 32'(out_instr_valid), 1);
    in_instr_ready = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("t6_idle_addr", 32'(out_mem_addr), 1);
      chk("t6_idle_valid", 32'(out_instr_valid), 0);
      tick;
    end
    in_enable = 1'b1;
    sb.push_back({9'd1, 16'h0F0F});
    repeat (3) tick;
    in_enable = 1'b0;
    tick;
    tick;
    chk("t6_final_valid", 32'(out_instr_valid), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
